// File: rtl/el2_dec_gpr_wport_arb_if.sv
// rtl/el2_dec_gpr_wport_arb_if.sv - writeback requester bundle for the GPR write-port scheduler
interface el2_dec_gpr_wport_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][4:0]  req_addr;
    logic [NREQ-1:0][31:0] req_data;
    logic [NREQ-1:0]       req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/el2_dec_gpr_wport_arb.sv
// rtl/el2_dec_gpr_wport_arb.sv - schedules NREQ writeback requesters onto three registered GPR write ports
module el2_dec_gpr_wport_arb #(
    parameter int NREQ       = 4,
    parameter int STARVE_LIM = 7
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   scan_mode,
    el2_dec_gpr_wport_arb_if.slave req,
    output logic                   wen0,
    output logic                   wen1,
    output logic                   wen2,
    output logic [4:0]             waddr0,
    output logic [4:0]             waddr1,
    output logic [4:0]             waddr2,
    output logic [31:0]            wd0,
    output logic [31:0]            wd1,
    output logic [31:0]            wd2
);
    localparam int         IW  = $clog2(NREQ);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [2:0]            rr_ptr;
    logic [2:0]            rr_nxt;
    logic [NREQ-1:1][3:0]  starve_cnt;
    logic [2:0]            wen_q, wen_d;
    logic [2:0][4:0]       waddr_q, waddr_d;
    logic [2:0][31:0]      wd_q, wd_d;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rdy;
    logic [NREQ-1:0]       zero_addr;
    logic                  unused_scan_mode;

    assign unused_scan_mode = scan_mode;

    always_comb begin
        zero_addr = '0;
        for (int i = 0; i < NREQ; i++) zero_addr[i] = (req.req_addr[i] == 5'd0);
    end

    // Slot 0 is requester 0, slots 1..NREQ-1 the starved pass, the rest walk round-robin from rr_ptr.
    always_comb begin : arb
        int             nport;
        int             idx;
        logic           elig;
        logic           clash;
        logic [IW-1:0]  ci;
        gnt     = '0;
        wen_d   = '0;
        waddr_d = '0;
        wd_d    = '0;
        rr_nxt  = rr_ptr;
        nport   = 0;
        idx     = 0;
        elig    = 1'b0;
        clash   = 1'b0;
        ci      = '0;
        for (int s = 0; s < 2*NREQ-1; s++) begin
            if (s == 0) begin
                idx  = 0;
                elig = 1'b1;
            end else if (s < NREQ) begin
                idx  = s;
                elig = (starve_cnt[s] == LIM);
            end else begin
                idx = int'(rr_ptr) + (s - NREQ);
                if (idx >= NREQ) idx = idx - (NREQ - 1);
                elig = 1'b1;
            end
            ci    = IW'(idx);
            clash = 1'b0;
            for (int p = 0; p < 3; p++)
                if (p < nport && waddr_d[p] == req.req_addr[ci]) clash = 1'b1;
            if (elig && rst_l && req.req_valid[ci] && !zero_addr[ci] && !gnt[ci]
                && nport < 3 && !clash) begin
                gnt[ci] = 1'b1;
                for (int p = 0; p < 3; p++) begin
                    if (p == nport) begin
                        wen_d[p]   = 1'b1;
                        waddr_d[p] = req.req_addr[ci];
                        wd_d[p]    = req.req_data[ci];
                    end
                end
                nport = nport + 1;
                if (s >= NREQ) rr_nxt = (idx == NREQ-1) ? 3'd1 : 3'(idx + 1);
            end
        end
    end

    // x0 writes are acknowledged immediately and never occupy a port.
    assign rdy           = rst_l ? (req.req_valid & (gnt | zero_addr)) : '0;
    assign req.req_ready = rdy;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wen_q      <= '0;
            waddr_q    <= '0;
            wd_q       <= '0;
            rr_ptr     <= 3'd1;
            starve_cnt <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wd_q    <= wd_d;
            rr_ptr  <= rr_nxt;
            for (int i = 1; i < NREQ; i++) begin
                if (req.req_valid[i] && !zero_addr[i] && !rdy[i])
                    starve_cnt[i] <= (starve_cnt[i] == LIM) ? LIM : starve_cnt[i] + 4'd1;
                else
                    starve_cnt[i] <= '0;
            end
        end
    end

    assign wen0   = wen_q[0];
    assign wen1   = wen_q[1];
    assign wen2   = wen_q[2];
    assign waddr0 = waddr_q[0];
    assign waddr1 = waddr_q[1];
    assign waddr2 = waddr_q[2];
    assign wd0    = wd_q[0];
    assign wd1    = wd_q[1];
    assign wd2    = wd_q[2];

`ifdef RV_ASSERT_ON
    always @(posedge clk) begin
        if (rst_l) begin
            assert (!(wen_q[0] && wen_q[1] && waddr_q[0] == waddr_q[1]) &&
                    !(wen_q[0] && wen_q[2] && waddr_q[0] == waddr_q[2]) &&
                    !(wen_q[1] && wen_q[2] && waddr_q[1] == waddr_q[2]));
            assert ((rdy & ~req.req_valid) == '0);
            assert ((!wen_q[1] || wen_q[0]) && (!wen_q[2] || wen_q[1]));
        end
    end
`endif
endmodule

// File: tb/tb_el2_dec_gpr_wport_arb.sv
// tb/tb_el2_dec_gpr_wport_arb.sv - scoreboard bench for the GPR write-port scheduler
module tb_el2_dec_gpr_wport_arb;
    localparam int NREQ = 4;

    logic        clk       = 1'b0;
    logic        rst_l     = 1'b1;
    logic        scan_mode = 1'b0;
    logic        wen0, wen1, wen2;
    logic [4:0]  waddr0, waddr1, waddr2;
    logic [31:0] wd0, wd1, wd2;
    logic        mon_en    = 1'b0;
    int          total     = 0;
    int          bad       = 0;
    int          seq       = 0;
    logic [113:0] expq[$];

    always #5 clk = ~clk;

    el2_dec_gpr_wport_arb_if #(.NREQ(NREQ)) rif ();

    el2_dec_gpr_wport_arb #(.NREQ(NREQ), .STARVE_LIM(2)) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .scan_mode(scan_mode),
        .req      (rif.slave),
        .wen0     (wen0),
        .wen1     (wen1),
        .wen2     (wen2),
        .waddr0   (waddr0),
        .waddr1   (waddr1),
        .waddr2   (waddr2),
        .wd0      (wd0),
        .wd1      (wd1),
        .wd2      (wd2)
    );

    function automatic logic [113:0] wport_now();
        return {wen2, wen1, wen0, waddr2, waddr1, waddr0, wd2, wd1, wd0};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // g0..g2: requester expected on port 0..2, -1 for an idle port
    task automatic cyc(input logic [3:0] v, input logic [3:0][4:0] a, input logic [3:0][31:0] d,
                       input logic [3:0] erdy, input int g0, input int g1, input int g2,
                       input string nm);
        logic [2:0]       ew;
        logic [2:0][4:0]  ea;
        logic [2:0][31:0] ed;
        int               g[3];
        @(negedge clk);
        rif.req_valid = v;
        rif.req_addr  = a;
        rif.req_data  = d;
        #1;
        chk({nm, "_ready"}, 128'(rif.req_ready), 128'(erdy));
        g[0] = g0; g[1] = g1; g[2] = g2;
        ew = '0; ea = '0; ed = '0;
        for (int p = 0; p < 3; p++) begin
            if (g[p] >= 0) begin
                ew[p] = 1'b1;
                ea[p] = a[g[p]];
                ed[p] = d[g[p]];
            end
        end
        expq.push_back({ew, ea, ed});
    endtask

    task automatic cyca(input logic [3:0] v, input logic [3:0][4:0] a, input logic [3:0] erdy,
                        input int g0, input int g1, input int g2, input string nm);
        logic [3:0][31:0] d;
        seq++;
        for (int i = 0; i < 4; i++) d[i] = (32'(i + 1) << 28) | (32'(seq) << 8) | 32'(a[i]);
        cyc(v, a, d, erdy, g0, g1, g2, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l         = 1'b0;
        rif.req_valid = 4'b1111;
        rif.req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        rif.req_data  = '0;
        #1;
        chk("rst_ready", 128'(rif.req_ready), 128'(0));
        chk("rst_wport", 128'(wport_now()), 128'(0));
        repeat (2) @(negedge clk);
        rif.req_valid = '0;
        rst_l         = 1'b1;
    endtask

    initial begin : monitor
        logic [113:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("wport", 128'(wport_now()), 128'(e));
                end else begin
                    chk("idle_wport", 128'(wport_now()), 128'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        rif.req_valid = '0;
        rif.req_addr  = '0;
        rif.req_data  = '0;
        do_reset();
        mon_en = 1'b1;

        // two writers share the cycle; then the round-robin pointer is seen at 2
        cyc(4'b0011, {5'd0, 5'd0, 5'd6, 5'd5}, {32'h0, 32'h0, 32'h11, 32'hA5A5A5A5},
            4'b0011, 0, 1, -1, "t1");
        cyca(4'b1110, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1110, 2, 3, 1, "t1_rr2");
        cyca(4'b0000, '0, 4'b0000, -1, -1, -1, "t1_idle");

        do_reset();
        cyc(4'b0101, {5'd0, 5'd7, 5'd0, 5'd7}, {32'h0, 32'h72, 32'h0, 32'h70},
            4'b0001, 0, -1, -1, "t2_conflict");
        cyc(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {32'h0, 32'h72, 32'h0, 32'h0},
            4'b0100, 2, -1, -1, "t2_retry");

        do_reset();
        cyca(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0111, 0, 1, 2, "t3_c1");
        cyca(4'b1111, {5'd4, 5'd3, 5'd2, 5'd5}, 4'b1011, 0, 3, 1, "t3_c2");
        cyca(4'b1111, {5'd4, 5'd3, 5'd2, 5'd6}, 4'b1101, 0, 2, 3, "t3_c3");
        cyca(4'b1111, {5'd4, 5'd3, 5'd2, 5'd7}, 4'b0111, 0, 1, 2, "t3_c4");

        do_reset();
        cyca(4'b1111, {5'd9, 5'd3, 5'd2, 5'd1}, 4'b0111, 0, 1, 2, "t4_c1");
        cyca(4'b1111, {5'd9, 5'd5, 5'd4, 5'd9}, 4'b0111, 0, 1, 2, "t4_c2");
        cyca(4'b1001, {5'd9, 5'd0, 5'd0, 5'd6}, 4'b1001, 0, 3, -1, "t4_starved");
        cyca(4'b1110, {5'd12, 5'd11, 5'd10, 5'd0}, 4'b1110, 3, 1, 2, "t4_rr_held");

        do_reset();
        cyca(4'b1111, {5'd3, 5'd2, 5'd0, 5'd1}, 4'b1111, 0, 2, 3, "t5_x0");

        do_reset();
        cyca(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0111, 0, 1, 2, "t6_pre");
        @(posedge clk);
        #3;
        rst_l = 1'b0;
        #1;
        chk("t6_async_wport", 128'(wport_now()), 128'(0));
        chk("t6_rst_ready", 128'(rif.req_ready), 128'(0));
        @(negedge clk);
        rif.req_valid = '0;
        rst_l         = 1'b1;
        cyca(4'b1110, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1110, 1, 2, 3, "t6_post");
        cyca(4'b0000, '0, 4'b0000, -1, -1, -1, "tail");

        repeat (3) @(negedge clk);
        chk("queue_drained", 128'(expq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
